// File: rtl/uart_rx_pkg.sv
// Shared UART receiver definitions: data width, parity encodings, default
// baud constant, receiver state encoding and the parity helper.
package uart_rx_pkg;

  localparam int FRAME_BITS           = 11;
  localparam int DATA_BITS            = 8;
  localparam int PARITY_EVEN          = 0;
  localparam int PARITY_ODD           = 1;
  localparam int DEFAULT_CLKS_PER_BIT = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_PAR   = 3'd3,
    S_STOP  = 3'd4,
    S_BRK   = 3'd5
  } rx_state_t;

  // Parity bit the transmitter puts on the line for a given byte.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d, input int mode);
    return (mode == PARITY_ODD) ? ~(^d) : (^d);
  endfunction

endpackage

// File: rtl/rx_sync.sv
// Multi-flop synchroniser for an asynchronous level input; resets to 1 so an
// idle-high line does not look like a falling edge when reset releases.
module rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  // Shift the raw input through the flop chain, oldest sample at the MSB.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '1;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data (LSB first), 1 parity, 1 stop bit. Samples
// mid-bit using a counter aligned to the start edge and reports each byte
// with a single-cycle valid strobe plus parity/framing status.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY       = PARITY_EVEN,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  logic w_rxs;

  rx_state_t            r_state, w_state_next;
  logic [CNT_W-1:0]     r_cnt, w_cnt_next;
  logic [3:0]           r_idx, w_idx_next;
  logic [DATA_BITS-1:0] r_shift, w_shift_next;
  logic                 r_par, w_par_next;
  logic                 r_stop, w_stop_next;
  logic                 r_done, w_done_next;
  logic [DATA_BITS-1:0] r_data, w_data_next;
  logic                 r_valid, w_valid_next;
  logic                 r_perr, w_perr_next;
  logic                 r_ferr, w_ferr_next;

  rx_sync #(
    .STAGES(SYNC_STAGES)
  ) u_rx_sync (
    .clk  (clk),
    .reset(reset),
    .d    (rx),
    .q    (w_rxs)
  );

  // State, bit timing, shift register and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_stop  <= 1'b0;
      r_done  <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_idx   <= w_idx_next;
      r_shift <= w_shift_next;
      r_par   <= w_par_next;
      r_stop  <= w_stop_next;
      r_done  <= w_done_next;
      r_data  <= w_data_next;
      r_valid <= w_valid_next;
      r_perr  <= w_perr_next;
      r_ferr  <= w_ferr_next;
    end
  end

  // Next-state and datapath decisions; every sample is taken when cnt hits 0.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    w_par_next   = r_par;
    w_stop_next  = r_stop;
    w_done_next  = r_done;
    w_data_next  = r_data;
    w_valid_next = 1'b0;
    w_perr_next  = r_perr;
    w_ferr_next  = r_ferr;

    case (r_state)
      S_IDLE: begin
        // Half-bit wait puts the start sample in the middle of the start bit.
        if (!w_rxs) begin
          w_cnt_next   = CNT_HALF;
          w_state_next = S_START;
        end
      end

      S_START: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - 1'b1;
        end else if (w_rxs) begin
          w_state_next = S_IDLE;   // line went back high: treat as a glitch
        end else begin
          w_cnt_next   = CNT_FULL;
          w_idx_next   = 4'd0;
          w_state_next = S_DATA;
        end
      end

      S_DATA: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - 1'b1;
        end else begin
          w_shift_next[r_idx[2:0]] = w_rxs;
          w_cnt_next               = CNT_FULL;
          w_idx_next               = r_idx + 4'd1;
          if (r_idx == 4'd7) begin
            w_state_next = S_PAR;
          end
        end
      end

      S_PAR: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - 1'b1;
        end else begin
          w_par_next   = w_rxs;
          w_cnt_next   = CNT_FULL;
          w_done_next  = 1'b0;
          w_state_next = S_STOP;
        end
      end

      S_STOP: begin
        // The stop sample is registered first; the frame is published on
        // the following clock, which is also when IDLE is re-entered.
        if (r_done) begin
          w_valid_next = 1'b1;
          w_data_next  = r_shift;
          w_perr_next  = (r_par != parity_bit(r_shift, PARITY));
          w_ferr_next  = ~r_stop;
          w_done_next  = 1'b0;
          w_state_next = r_stop ? S_IDLE : S_BRK;
        end else if (r_cnt != '0) begin
          w_cnt_next = r_cnt - 1'b1;
        end else begin
          w_stop_next = w_rxs;
          w_done_next = 1'b1;
        end
      end

      S_BRK: begin
        // A line held low after a bad stop bit yields one frame only.
        if (w_rxs) begin
          w_state_next = S_IDLE;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  assign rx_data    = r_data;
  assign rx_valid   = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign rx_busy    = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx: an even-parity and an odd-parity
// receiver listen to the same line; expected frames are queued when sent
// and popped by per-receiver monitors on each rx_valid.
module tb_uart_rx;

  localparam int C = 4;

  typedef struct {
    logic [7:0] d;
    logic       perr_e;
    logic       perr_o;
    logic       ferr;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;

  logic [7:0] data_e, data_o;
  logic       valid_e, valid_o, perr_e, perr_o, ferr_e, ferr_o, busy_e, busy_o;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  exp_t q_even[$];
  exp_t q_odd[$];

  logic [7:0] hd_e = 8'h00, hd_o = 8'h00;
  logic       hp_e = 1'b0, hp_o = 1'b0, hf_e = 1'b0, hf_o = 1'b0;

  uart_rx #(.CLKS_PER_BIT(C), .PARITY(0), .SYNC_STAGES(2)) dut_even (
    .clk(clk), .reset(reset), .rx(rx), .rx_data(data_e), .rx_valid(valid_e),
    .parity_err(perr_e), .frame_err(ferr_e), .rx_busy(busy_e)
  );

  uart_rx #(.CLKS_PER_BIT(C), .PARITY(1), .SYNC_STAGES(2)) dut_odd (
    .clk(clk), .reset(reset), .rx(rx), .rx_data(data_o), .rx_valid(valid_o),
    .parity_err(perr_o), .frame_err(ferr_o), .rx_busy(busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one whole frame; the expected result is queued before the line moves.
  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    logic [10:0] bits;
    exp_t        e;
    bits     = {s, p, d, 1'b0};
    e.d      = d;
    e.perr_e = p ^ (^d);
    e.perr_o = p ^ ~(^d);
    e.ferr   = ~s;
    e.cyc    = cyc + 46;
    q_even.push_back(e);
    q_odd.push_back(e);
    $display("send d=%02h p=%0b stop=%0b at cycle %0d", d, p, s, cyc);
    for (int i = 0; i < 11; i++) begin
      rx = bits[i];
      repeat (C) begin @(posedge clk); #1; end
    end
  endtask

  task automatic idle_cycles(input int n);
    rx = 1'b1;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Even-parity receiver monitor.
  always @(negedge clk) begin
    if (!reset) begin
      chk("reset_even_outs", {data_e, valid_e, perr_e, ferr_e, busy_e}, 32'h0);
      hd_e = 8'h00; hp_e = 1'b0; hf_e = 1'b0;
    end else if (valid_e) begin
      if (q_even.size() == 0) begin
        chk("even_unexpected_valid", {24'h0, data_e}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q_even.pop_front();
        $display("even rx d=%02h perr=%0b ferr=%0b cycle=%0d (exp d=%02h perr=%0b ferr=%0b cycle=%0d)",
                 data_e, perr_e, ferr_e, cyc, e.d, e.perr_e, e.ferr, e.cyc);
        chk("even_data", {24'h0, data_e}, {24'h0, e.d});
        chk("even_perr", {31'h0, perr_e}, {31'h0, e.perr_e});
        chk("even_ferr", {31'h0, ferr_e}, {31'h0, e.ferr});
        chk("even_latency", cyc, e.cyc);
        hd_e = e.d; hp_e = e.perr_e; hf_e = e.ferr;
      end
    end else begin
      chk("even_hold", {22'h0, data_e, perr_e, ferr_e}, {22'h0, hd_e, hp_e, hf_e});
    end
  end

  // Odd-parity receiver monitor.
  always @(negedge clk) begin
    if (!reset) begin
      chk("reset_odd_outs", {data_o, valid_o, perr_o, ferr_o, busy_o}, 32'h0);
      hd_o = 8'h00; hp_o = 1'b0; hf_o = 1'b0;
    end else if (valid_o) begin
      if (q_odd.size() == 0) begin
        chk("odd_unexpected_valid", {24'h0, data_o}, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = q_odd.pop_front();
        $display("odd  rx d=%02h perr=%0b ferr=%0b cycle=%0d (exp d=%02h perr=%0b ferr=%0b cycle=%0d)",
                 data_o, perr_o, ferr_o, cyc, e.d, e.perr_o, e.ferr, e.cyc);
        chk("odd_data", {24'h0, data_o}, {24'h0, e.d});
        chk("odd_perr", {31'h0, perr_o}, {31'h0, e.perr_o});
        chk("odd_ferr", {31'h0, ferr_o}, {31'h0, e.ferr});
        chk("odd_latency", cyc, e.cyc);
        hd_o = e.d; hp_o = e.perr_o; hf_o = e.ferr;
      end
    end else begin
      chk("odd_hold", {22'h0, data_o, perr_o, ferr_o}, {22'h0, hd_o, hp_o, hf_o});
    end
  end

  initial begin
    logic       seen;
    logic [7:0] d;
    logic       wrong;

    // Reset held with a toggling line: monitors check all outputs are zero.
    #2 reset = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      rx = 1'($urandom_range(0, 1));
    end
    rx = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    idle_cycles(30);
    chk("idle_busy", {30'h0, busy_e, busy_o}, 32'h0);

    // Directed frames: good parity, wrong parity.
    send_frame(8'hA5, 1'b0, 1'b1);
    idle_cycles(8);
    send_frame(8'h3C, 1'b1, 1'b1);
    idle_cycles(8);

    // Bad stop bit followed by a long break: one frame, then silence.
    send_frame(8'h81, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (30 * C) begin @(posedge clk); #1; end
    chk("break_busy", {30'h0, busy_e, busy_o}, 32'h3);
    idle_cycles(10);
    chk("after_break_busy", {30'h0, busy_e, busy_o}, 32'h0);

    // Short low glitches on an idle line.
    for (int g = 1; g <= 2; g++) begin
      rx = 1'b0;
      repeat (g) begin @(posedge clk); #1; end
      rx = 1'b1;
      seen = 1'b0;
      repeat (12) begin
        @(negedge clk);
        seen = seen | busy_e;
      end
      $display("glitch len=%0d busy_seen=%0b", g, seen);
      chk("glitch_busy_pulse", {31'h0, seen}, 32'h1);
      chk("glitch_back_idle", {30'h0, busy_e, busy_o}, 32'h0);
      @(posedge clk); #1;
    end

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b0, 1'b1);
    send_frame(8'hFF, 1'b0, 1'b1);
    send_frame(8'h55, 1'b0, 1'b1);
    idle_cycles(8);

    // Reset mid-byte: partial frame must vanish.
    rx = 1'b0;
    repeat (C) begin @(posedge clk); #1; end
    for (int b = 0; b < 3; b++) begin
      rx = 1'(b & 1);
      repeat (C) begin @(posedge clk); #1; end
    end
    reset = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rx = 1'b1;
    @(posedge clk); #1;
    reset = 1'b1;
    idle_cycles(60);
    send_frame(8'h6B, 1'b1, 1'b1);
    idle_cycles(6);

    // Random frames, roughly a quarter with wrong parity, random idle gaps.
    for (int i = 0; i < 20; i++) begin
      d     = 8'($urandom);
      wrong = ($urandom_range(0, 3) == 0);
      send_frame(d, (^d) ^ wrong, 1'b1);
      idle_cycles($urandom_range(0, 6));
    end

    idle_cycles(60);
    chk("even_queue_drained", q_even.size(), 32'h0);
    chk("odd_queue_drained", q_odd.size(), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
